// File: rtl/demux_rr_scheduler_pkg.sv
// Shared constants and FSM encoding for the round-robin demux scheduler.
`ifndef DEMUX_RR_SCHEDULER_PKG_SV
`define DEMUX_RR_SCHEDULER_PKG_SV

package demux_rr_scheduler_pkg;

    localparam int unsigned NUM_DEST          = 16;
    localparam int unsigned KEY_W             = 4;
    localparam int unsigned DEFAULT_BURST_LEN = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2
    } state_e;

endpackage

`endif

// File: rtl/demux_rr_scheduler_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod 16.
module rr_priority_pick_16
    import demux_rr_scheduler_pkg::*;
(
    input  logic [NUM_DEST-1:0] req,
    input  logic [KEY_W-1:0]    ptr,
    output logic [KEY_W-1:0]    winner,
    output logic                found
);

    logic [NUM_DEST-1:0] rot;
    logic [KEY_W-1:0]    enc;

    // Rotate so that bit 0 corresponds to the destination at ptr.
    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_DEST; i++) begin
            rot[i] = req[KEY_W'(i) + ptr];
        end
    end

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        enc   = '0;
        found = 1'b0;
        for (int i = NUM_DEST - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc   = KEY_W'(i);
                found = 1'b1;
            end
        end
    end

    assign winner = enc + ptr;

endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin burst scheduler driving a 16-way 1-bit demux key/enable from one serial source.
module demux_rr_scheduler
    import demux_rr_scheduler_pkg::*;
#(
    parameter int unsigned BURST_LEN = DEFAULT_BURST_LEN,
    parameter int unsigned CNT_W     = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] req,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [3:0]  key,
    output logic        enable,
    output logic [15:0] grant,
    output logic        busy
);

    state_e           state;
    logic [KEY_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [KEY_W-1:0] winner;
    logic             found;
    logic             beat;
    logic             last_beat;
    logic             burst_end;

    rr_priority_pick_16 u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .found  (found)
    );

    // A beat moves only when the held destination still wants data and the source has it.
    assign beat      = (state == ST_XFER) && src_valid && req[key];
    assign last_beat = beat && (cnt == CNT_W'(BURST_LEN - 1));
    assign burst_end = (state == ST_XFER) && (!req[key] || last_beat);

    assign src_ready = beat;
    assign enable    = beat;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            ptr   <= '0;
            key   <= '0;
            grant <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) state <= ST_ARB;
                end
                ST_ARB: begin
                    if (found) begin
                        key   <= winner;
                        grant <= NUM_DEST'(1) << winner;
                        cnt   <= '0;
                        state <= ST_XFER;
                    end else begin
                        grant <= '0;
                        state <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    // Served destination drops to lowest priority for the next pick.
                    if (burst_end) begin
                        ptr   <= key + KEY_W'(1);
                        grant <= '0;
                        cnt   <= '0;
                        state <= (|req) ? ST_ARB : ST_IDLE;
                    end else if (beat) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
